// File: rtl/fir_block_master.sv
// Bus-mastering FIR filter: loads NUM_TAPS coefficients, then streams samples from base_x,
// filters them one tap per cycle, and writes each output word to base_y.
module fir_block_master #(
  parameter int NUM_TAPS = 8,
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int ACC_W    = DATA_W + COEF_W + $clog2(NUM_TAPS)
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iChipSelect_Control,
  input  logic        iWrite_Control,
  input  logic        iRead_Control,
  input  logic [4:0]  iAddress_Control,
  input  logic [31:0] iData_Control,
  output logic [31:0] oData_Control,
  output logic [31:0] oAddress_Master_Read,
  output logic        oRead_Master_Read,
  input  logic [31:0] iReadData_Master_Read,
  input  logic        iWait_Master_Read,
  output logic [31:0] oAddress_Master_Write,
  output logic        oWrite_Master_Write,
  output logic [31:0] oWriteData_Master_Write,
  input  logic        iWait_Master_Write,
  output logic        oIrq
);

  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_H  = 3'd1;
  localparam logic [2:0] S_READ_X  = 3'd2;
  localparam logic [2:0] S_MAC     = 3'd3;
  localparam logic [2:0] S_WRITE_Y = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]               state_q,      state_d;
  logic [31:0]              baseX_q,      baseX_d;
  logic [31:0]              baseH_q,      baseH_d;
  logic [31:0]              baseY_q,      baseY_d;
  logic [15:0]              length_q,     length_d;
  logic [15:0]              count_q,      count_d;
  logic                     irqEn_q,      irqEn_d;
  logic                     done_q,       done_d;
  logic                     aborted_q,    aborted_d;
  logic                     abortPend_q,  abortPend_d;
  logic [TAP_W-1:0]         tap_q,        tap_d;
  logic signed [ACC_W-1:0]  acc_q,        acc_d;
  logic [31:0]              rdData_q,     rdData_d;
  logic signed [COEF_W-1:0] h_q [NUM_TAPS];
  logic signed [COEF_W-1:0] h_d [NUM_TAPS];
  logic signed [DATA_W-1:0] x_q [NUM_TAPS];
  logic signed [DATA_W-1:0] x_d [NUM_TAPS];

  logic                     busy;
  logic                     csWrite;
  logic                     csRead;
  logic                     startPulse;
  logic                     abortPulse;
  logic                     abortReq;
  logic                     rdStrobe;
  logic                     wrStrobe;
  logic                     readAccept;
  logic                     writeAccept;
  logic                     moreSamples;
  logic signed [PROD_W-1:0] prod;
  logic signed [31:0]       accExt;

  // DONE is a one-cycle completion marker, so only the working states count as busy.
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign csWrite     = iChipSelect_Control && iWrite_Control;
  assign csRead      = iChipSelect_Control && iRead_Control;
  assign startPulse  = csWrite && (iAddress_Control == 5'd3) && iData_Control[0];
  assign abortPulse  = csWrite && (iAddress_Control == 5'd3) && iData_Control[2];
  assign abortReq    = abortPend_q || (abortPulse && busy);
  assign rdStrobe    = (state_q == S_LOAD_H) || (state_q == S_READ_X);
  assign wrStrobe    = (state_q == S_WRITE_Y);
  assign readAccept  = rdStrobe && !iWait_Master_Read;
  assign writeAccept = wrStrobe && !iWait_Master_Write;
  assign moreSamples = ({1'b0, count_q} + 17'd1) < {1'b0, length_q};
  assign prod        = PROD_W'(h_q[tap_q]) * PROD_W'(x_q[tap_q]);
  assign accExt      = 32'(acc_q);

  // Master outputs are decoded from registered state, so they cannot move during a wait.
  assign oRead_Master_Read       = rdStrobe;
  assign oAddress_Master_Read    = (state_q == S_LOAD_H) ? baseH_q + 32'(tap_q) :
                                   (state_q == S_READ_X) ? baseX_q + 32'(count_q) : 32'd0;
  assign oWrite_Master_Write     = wrStrobe;
  assign oAddress_Master_Write   = wrStrobe ? baseY_q + 32'(count_q) : 32'd0;
  assign oWriteData_Master_Write = wrStrobe ? accExt : 32'd0;
  assign oData_Control           = rdData_q;
  assign oIrq                    = done_q && irqEn_q;

  always_comb begin
    state_d     = state_q;
    baseX_d     = baseX_q;
    baseH_d     = baseH_q;
    baseY_d     = baseY_q;
    length_d    = length_q;
    count_d     = count_q;
    irqEn_d     = irqEn_q;
    done_d      = done_q;
    aborted_d   = aborted_q;
    abortPend_d = abortPend_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    rdData_d    = rdData_q;
    h_d         = h_q;
    x_d         = x_q;

    if (csWrite) begin
      case (iAddress_Control)
        5'd0: if (!busy) baseX_d = iData_Control;
        5'd1: if (!busy) baseH_d = iData_Control;
        5'd2: if (!busy) baseY_d = iData_Control;
        5'd3: irqEn_d = iData_Control[1];
        5'd4: begin
          if (iData_Control[0]) done_d = 1'b0;
          if (iData_Control[2]) aborted_d = 1'b0;
        end
        5'd5: if (!busy) length_d = iData_Control[15:0];
        default: ;
      endcase
    end

    if (abortPulse && busy) abortPend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        abortPend_d = 1'b0;
        if (startPulse) begin
          done_d    = 1'b0;
          aborted_d = 1'b0;
          count_d   = 16'd0;
          tap_d     = '0;
          if (length_q == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD_H;
          end
        end
      end
      S_LOAD_H: begin
        for (int k = 0; k < NUM_TAPS; k++) x_d[k] = '0;
        if (readAccept) begin
          h_d[tap_q] = iReadData_Master_Read[COEF_W-1:0];
          if (abortReq) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
            done_d    = 1'b0;
          end else if (tap_q == LAST_TAP) begin
            state_d = S_READ_X;
            tap_d   = '0;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end
      S_READ_X: begin
        if (readAccept) begin
          x_d[0] = iReadData_Master_Read[DATA_W-1:0];
          for (int k = 1; k < NUM_TAPS; k++) x_d[k] = x_q[k-1];
          acc_d = '0;
          tap_d = '0;
          if (abortReq) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
            done_d    = 1'b0;
          end else begin
            state_d = S_MAC;
          end
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (abortReq) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
          done_d    = 1'b0;
        end else if (tap_q == LAST_TAP) begin
          state_d = S_WRITE_Y;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      S_WRITE_Y: begin
        if (writeAccept) begin
          count_d = count_q + 16'd1;
          if (abortReq) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
            done_d    = 1'b0;
          end else if (moreSamples) begin
            state_d = S_READ_X;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        abortPend_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (csRead) begin
      case (iAddress_Control)
        5'd0:    rdData_d = baseX_q;
        5'd1:    rdData_d = baseH_q;
        5'd2:    rdData_d = baseY_q;
        5'd3:    rdData_d = {30'd0, irqEn_q, 1'b0};
        5'd4:    rdData_d = {29'd0, aborted_q, busy, done_q};
        5'd5:    rdData_d = {16'd0, length_q};
        5'd6:    rdData_d = {16'd0, count_q};
        default: rdData_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= S_IDLE;
      baseX_q     <= '0;
      baseH_q     <= '0;
      baseY_q     <= '0;
      length_q    <= '0;
      count_q     <= '0;
      irqEn_q     <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      abortPend_q <= 1'b0;
      tap_q       <= '0;
      acc_q       <= '0;
      rdData_q    <= '0;
      h_q         <= '{default: '0};
      x_q         <= '{default: '0};
    end else begin
      state_q     <= state_d;
      baseX_q     <= baseX_d;
      baseH_q     <= baseH_d;
      baseY_q     <= baseY_d;
      length_q    <= length_d;
      count_q     <= count_d;
      irqEn_q     <= irqEn_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      abortPend_q <= abortPend_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      rdData_q    <= rdData_d;
      h_q         <= h_d;
      x_q         <= x_d;
    end
  end

endmodule

// File: tb/tb_fir_block_master.sv
// Directed bench for fir_block_master: a 256-word memory model serves both masters,
// optionally with random wait states, and each task checks one scenario.
module tb_fir_block_master;

  logic        iClk;
  logic        iRst;
  logic        iChipSelect_Control;
  logic        iWrite_Control;
  logic        iRead_Control;
  logic [4:0]  iAddress_Control;
  logic [31:0] iData_Control;
  logic [31:0] oData_Control;
  logic [31:0] oAddress_Master_Read;
  logic        oRead_Master_Read;
  logic [31:0] iReadData_Master_Read;
  logic        iWait_Master_Read;
  logic [31:0] oAddress_Master_Write;
  logic        oWrite_Master_Write;
  logic [31:0] oWriteData_Master_Write;
  logic        iWait_Master_Write;
  logic        oIrq;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [256];
  logic        waitMode = 1'b0;
  int          rdCycles = 0;
  int          wrCycles = 0;
  int          wrDone = 0;
  int          overlap = 0;
  int          stableErr = 0;
  logic        prevRdStall = 1'b0;
  logic        prevWrStall = 1'b0;
  logic [31:0] prevRAddr = '0;
  logic [31:0] prevWAddr = '0;
  logic [31:0] prevWData = '0;

  fir_block_master dut (
    .iClk                    (iClk),
    .iRst                    (iRst),
    .iChipSelect_Control     (iChipSelect_Control),
    .iWrite_Control          (iWrite_Control),
    .iRead_Control           (iRead_Control),
    .iAddress_Control        (iAddress_Control),
    .iData_Control           (iData_Control),
    .oData_Control           (oData_Control),
    .oAddress_Master_Read    (oAddress_Master_Read),
    .oRead_Master_Read       (oRead_Master_Read),
    .iReadData_Master_Read   (iReadData_Master_Read),
    .iWait_Master_Read       (iWait_Master_Read),
    .oAddress_Master_Write   (oAddress_Master_Write),
    .oWrite_Master_Write     (oWrite_Master_Write),
    .oWriteData_Master_Write (oWriteData_Master_Write),
    .iWait_Master_Write      (iWait_Master_Write),
    .oIrq                    (oIrq)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  assign iReadData_Master_Read = mem[oAddress_Master_Read[7:0]];

  // Bus slave model: picks the wait seen at the next rising edge and commits accepted writes.
  always @(negedge iClk) begin
    if (prevRdStall && (oRead_Master_Read !== 1'b1 || oAddress_Master_Read !== prevRAddr))
      stableErr++;
    if (prevWrStall && (oWrite_Master_Write !== 1'b1 || oAddress_Master_Write !== prevWAddr ||
                        oWriteData_Master_Write !== prevWData))
      stableErr++;
    if (oRead_Master_Read && oWrite_Master_Write) overlap++;
    if (oRead_Master_Read) rdCycles++;
    if (oWrite_Master_Write) wrCycles++;
    iWait_Master_Read  = waitMode ? 1'($urandom_range(0, 1)) : 1'b0;
    iWait_Master_Write = waitMode ? 1'($urandom_range(0, 1)) : 1'b0;
    if (oWrite_Master_Write && !iWait_Master_Write) begin
      mem[oAddress_Master_Write[7:0]] = oWriteData_Master_Write;
      wrDone++;
    end
    prevRdStall = oRead_Master_Read && iWait_Master_Read;
    prevWrStall = oWrite_Master_Write && iWait_Master_Write;
    prevRAddr   = oAddress_Master_Read;
    prevWAddr   = oAddress_Master_Write;
    prevWData   = oWriteData_Master_Write;
  end

  task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d);
    @(negedge iClk);
    iChipSelect_Control = 1'b1;
    iWrite_Control      = 1'b1;
    iAddress_Control    = a;
    iData_Control       = d;
    @(negedge iClk);
    iChipSelect_Control = 1'b0;
    iWrite_Control      = 1'b0;
  endtask

  task automatic readReg(input logic [4:0] a, output logic [31:0] v);
    @(negedge iClk);
    iChipSelect_Control = 1'b1;
    iRead_Control       = 1'b1;
    iAddress_Control    = a;
    @(negedge iClk);
    iChipSelect_Control = 1'b0;
    iRead_Control       = 1'b0;
    v = oData_Control;
  endtask

  task automatic waitDone(output logic ok);
    logic [31:0] s;
    ok = 1'b0;
    for (int i = 0; i < 800 && !ok; i++) begin
      readReg(5'd4, s);
      if (s[0] || s[2]) ok = 1'b1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL waitDone: status never showed done/aborted, got %h want done", s);
    end
  endtask

  task automatic startRun(input logic [31:0] bx, input logic [31:0] bh, input logic [31:0] by,
                          input logic [15:0] len);
    applyStimulus(5'd0, bx);
    applyStimulus(5'd1, bh);
    applyStimulus(5'd2, by);
    applyStimulus(5'd5, {16'd0, len});
    applyStimulus(5'd3, 32'h3);
  endtask

  task automatic checkImpulse(input string tag, input logic [7:0] by);
    logic [31:0] v;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (mem[by + 8'(i)] !== 32'(i + 1)) begin
        miscompares++;
        $display("[TB] FAIL %s y[%0d]: got %h want %h", tag, i, mem[by + 8'(i)], 32'(i + 1));
      end
    end
    readReg(5'd6, v);
    vectors++;
    if (v !== 32'd8) begin
      miscompares++;
      $display("[TB] FAIL %s count: got %0d want 8", tag, v);
    end
    readReg(5'd4, v);
    vectors++;
    if (v !== 32'h1) begin
      miscompares++;
      $display("[TB] FAIL %s status: got %h want 00000001", tag, v);
    end
    vectors++;
    if (oIrq !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s irq: got %b want 1", tag, oIrq);
    end
  endtask

  task automatic checkAllZero(input string tag);
    logic [31:0] v;
    for (int a = 0; a < 8; a++) begin
      readReg(5'(a), v);
      vectors++;
      if (v !== 32'd0) begin
        miscompares++;
        $display("[TB] FAIL %s reg%0d: got %h want 00000000", tag, a, v);
      end
    end
    vectors++;
    if (oIrq !== 1'b0 || oRead_Master_Read !== 1'b0 || oWrite_Master_Write !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s outputs: irq/rd/wr got %b%b%b want 000", tag, oIrq,
               oRead_Master_Read, oWrite_Master_Write);
    end
  endtask

  task automatic test_reset;
    checkAllZero("reset");
  endtask

  task automatic test_impulse;
    logic ok;
    for (int i = 0; i < 8; i++) begin
      mem[8'h40 + 8'(i)] = 32'(i + 1);
      mem[8'h00 + 8'(i)] = (i == 0) ? 32'd1 : 32'd0;
    end
    startRun(32'h00, 32'h40, 32'h80, 16'd8);
    waitDone(ok);
    checkImpulse("impulse", 8'h80);
  endtask

  task automatic test_signed;
    logic ok;
    int   e;
    for (int i = 0; i < 8; i++) mem[8'h50 + 8'(i)] = 32'h0000_00FF;
    for (int i = 0; i < 10; i++) mem[8'h10 + 8'(i)] = 32'h0000_007F;
    startRun(32'h10, 32'h50, 32'hA0, 16'd10);
    waitDone(ok);
    for (int i = 0; i < 10; i++) begin
      e = -127 * ((i < 8) ? (i + 1) : 8);
      vectors++;
      if (mem[8'hA0 + 8'(i)] !== 32'(e)) begin
        miscompares++;
        $display("[TB] FAIL signed y[%0d]: got %h want %h", i, mem[8'hA0 + 8'(i)], 32'(e));
      end
    end
    vectors++;
    if (mem[8'hA9] !== 32'hFFFF_FC08) begin
      miscompares++;
      $display("[TB] FAIL signed last: got %h want fffffc08", mem[8'hA9]);
    end
  endtask

  task automatic test_wait_states;
    logic ok;
    int   se0;
    int   ov0;
    for (int i = 0; i < 8; i++) mem[8'hC0 + 8'(i)] = 32'hDEAD_BEEF;
    se0 = stableErr;
    ov0 = overlap;
    waitMode = 1'b1;
    startRun(32'h00, 32'h40, 32'hC0, 16'd8);
    waitDone(ok);
    waitMode = 1'b0;
    checkImpulse("waits", 8'hC0);
    vectors++;
    if (stableErr - se0 != 0) begin
      miscompares++;
      $display("[TB] FAIL waits stability: got %0d changes during wait want 0", stableErr - se0);
    end
    vectors++;
    if (overlap - ov0 != 0) begin
      miscompares++;
      $display("[TB] FAIL waits overlap: got %0d cycles with both strobes want 0", overlap - ov0);
    end
  endtask

  task automatic test_length_zero;
    logic [31:0] v;
    int          r0;
    int          w0;
    applyStimulus(5'd4, 32'h5);
    applyStimulus(5'd5, 32'd0);
    r0 = rdCycles;
    w0 = wrCycles;
    applyStimulus(5'd3, 32'h3);
    vectors++;
    if (oIrq !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL len0 irq: got %b want 1", oIrq);
    end
    readReg(5'd4, v);
    vectors++;
    if (v !== 32'h1) begin
      miscompares++;
      $display("[TB] FAIL len0 status: got %h want 00000001", v);
    end
    repeat (4) @(negedge iClk);
    vectors++;
    if (rdCycles != r0 || wrCycles != w0) begin
      miscompares++;
      $display("[TB] FAIL len0 bus: got rd=%0d wr=%0d strobe cycles want 0 0",
               rdCycles - r0, wrCycles - w0);
    end
  endtask

  task automatic test_busy_start;
    logic ok;
    for (int i = 0; i < 8; i++) mem[8'hE0 + 8'(i)] = 32'h0;
    startRun(32'h00, 32'h40, 32'hE0, 16'd8);
    applyStimulus(5'd0, 32'h10);
    applyStimulus(5'd3, 32'h3);
    applyStimulus(5'd5, 32'd3);
    waitDone(ok);
    checkImpulse("busy", 8'hE0);
  endtask

  task automatic test_abort;
    logic [31:0] v;
    int          w0;
    w0 = wrDone;
    startRun(32'h00, 32'h40, 32'h90, 16'd8);
    repeat (10) @(negedge iClk);
    applyStimulus(5'd3, 32'h6);
    vectors++;
    if (oRead_Master_Read !== 1'b0 || oWrite_Master_Write !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort strobes: rd/wr got %b%b want 00", oRead_Master_Read,
               oWrite_Master_Write);
    end
    readReg(5'd4, v);
    vectors++;
    if (v !== 32'h4) begin
      miscompares++;
      $display("[TB] FAIL abort status: got %h want 00000004", v);
    end
    readReg(5'd6, v);
    vectors++;
    if (v !== 32'd0 || wrDone != w0 || oIrq !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort side effects: count=%0d writes=%0d irq=%b want 0 0 0",
               v, wrDone - w0, oIrq);
    end
  endtask

  task automatic test_reset_mid;
    int r0;
    int w0;
    startRun(32'h00, 32'h40, 32'h90, 16'd8);
    repeat (11) @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    r0 = rdCycles;
    w0 = wrCycles;
    checkAllZero("midreset");
    repeat (20) @(negedge iClk);
    vectors++;
    if (rdCycles != r0 || wrCycles != w0) begin
      miscompares++;
      $display("[TB] FAIL midreset bus: got rd=%0d wr=%0d strobe cycles want 0 0",
               rdCycles - r0, wrCycles - w0);
    end
  endtask

  initial begin
    iRst                = 1'b1;
    iChipSelect_Control = 1'b0;
    iWrite_Control      = 1'b0;
    iRead_Control       = 1'b0;
    iAddress_Control    = '0;
    iData_Control       = '0;
    iWait_Master_Read   = 1'b0;
    iWait_Master_Write  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    repeat (3) @(negedge iClk);
    iRst = 1'b0;
    $display("[TB] starting fir_block_master tests");
    test_reset;
    test_impulse;
    test_signed;
    test_wait_states;
    test_length_zero;
    test_busy_start;
    test_abort;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
